// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch front end. Owns the program counter, addresses a
//   synchronous instruction memory (one-cycle read latency, no read enable)
//   and presents a valid-tagged IF/ID word to the decode stage.
//
//   A one-entry hold buffer absorbs hazard-unit stalls. The memory keeps
//   returning a word every cycle, so the presented word is parked here while
//   the memory re-reads pc_q. The next word is then ready on release.
//
//   A taken-branch redirect squashes the wrong-path fetch in flight. It costs
//   exactly one bubble.
//
// Parameters
//   RESET_PC      fetch address loaded on reset
//   IMEM_BYTES    memory size in bytes (power of 2); fetch addresses wrap
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          synchronous, active-high reset
//   stall_i        hold PC and the IF/ID output this cycle
//   redirect_i     taken branch; overrides stall_i
//   redirect_pc_i  branch target byte address
//   imem_addr_o    byte address to instruction memory (always pc_q)
//   imem_rdata_i   memory data for the address presented at the previous edge
//   if_id_pc_o     PC of the presented instruction
//   if_id_instr_o  presented instruction
//   if_id_valid_o  presented instruction is valid (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o
);

  // Word-aligned address mask: wraps within the memory and clears bits[1:0].
  localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES - 1) & ~32'h3;

  logic [31:0] pc_q,         pc_d;
  logic [31:0] resp_pc_q,    resp_pc_d;     // address whose data is on imem_rdata_i
  logic        resp_v_q,     resp_v_d;      // that data is a real (non-squashed) fetch
  logic        hold_v_q,     hold_v_d;      // hold buffer owns the output
  logic [31:0] hold_pc_q,    hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        hold_valid_q, hold_valid_d;

  assign imem_addr_o = pc_q;

  // The output mux selects only registered state and the memory data. The
  // stall and redirect inputs never reach the IF/ID outputs combinationally.
  always_comb begin
    if (hold_v_q) begin
      if_id_pc_o    = hold_pc_q;
      if_id_instr_o = hold_instr_q;
      if_id_valid_o = hold_valid_q;
    end else begin
      if_id_pc_o    = resp_pc_q;
      if_id_instr_o = imem_rdata_i;
      if_id_valid_o = resp_v_q;
    end
  end

  always_comb begin
    // NOTE: every *_d gets a default before any branch. A path that leaves a
    // signal unassigned would otherwise infer a latch.
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_v_d     = resp_v_q;
    hold_v_d     = hold_v_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    hold_valid_d = hold_valid_q;

    if (redirect_i) begin
      // The word arriving next cycle belongs to the wrong path. Mark it dead
      // and drop any parked word.
      pc_d     = redirect_pc_i & PC_MASK;
      resp_v_d = 1'b0;
      hold_v_d = 1'b0;
    end else if (stall_i) begin
      // Park the presented word once. Later stall cycles leave it alone,
      // because the memory output no longer matches it.
      if (!hold_v_q) begin
        hold_v_d     = 1'b1;
        hold_pc_d    = if_id_pc_o;
        hold_instr_d = if_id_instr_o;
        hold_valid_d = if_id_valid_o;
      end
    end else begin
      // Decode consumes the presented word (held or live). The memory output
      // now corresponds to pc_q, so it becomes the next presented word.
      resp_pc_d = pc_q;
      resp_v_d  = 1'b1;
      pc_d      = (pc_q + 32'd4) & PC_MASK;
      hold_v_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    if (reset) begin
      pc_q         <= RESET_PC & PC_MASK;
      resp_pc_q    <= '0;
      resp_v_q     <= 1'b0;
      hold_v_q     <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_v_q     <= resp_v_d;
      hold_v_q     <= hold_v_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_valid_q <= hold_valid_d;
    end
  end

endmodule
